// File: rtl/mem_stage.sv
// LEGv8 memory stage: EX/MEM register, CBZ/B resolution, req/ack data-memory FSM with timeout, MEM/WB register.
// Define CBNZ_EN to resolve Branch==11 as CBNZ; otherwise that encoding is never taken.
module mem_stage #(
    parameter int ACK_TIMEOUT = 16,
    parameter int REG_BITS    = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                RegWrite_E,
    input  logic                MemtoReg_E,
    input  logic                MemRead_E,
    input  logic                MemWrite_E,
    input  logic [1:0]          Branch_E,
    input  logic [REG_BITS-1:0] rd_E,
    input  logic [63:0]         aluResult_E,
    input  logic [63:0]         writeData_E,
    input  logic [63:0]         PCBranch_E,
    input  logic                zero_E,
    input  logic                flush_i,
    output logic                stall_o,
    output logic                PCSrc_M,
    output logic [63:0]         PCBranch_M,
    output logic                dm_req,
    output logic                dm_we,
    output logic [63:0]         dm_addr,
    output logic [63:0]         dm_wdata,
    input  logic [63:0]         dm_rdata,
    input  logic                dm_ack,
    output logic                RegWrite_W,
    output logic                MemtoReg_W,
    output logic [REG_BITS-1:0] rd_W,
    output logic [63:0]         aluResult_W,
    output logic [63:0]         readData_W,
    output logic                mem_err_o
);

    localparam int                CNT_W    = $clog2(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic {IDLE, REQ} state_t;

    typedef struct packed {
        logic                valid;
        logic                reg_write;
        logic                mem_to_reg;
        logic                mem_read;
        logic                mem_write;
        logic [1:0]          branch;
        logic [REG_BITS-1:0] rd;
        logic [63:0]         alu;
        logic [63:0]         wdata;
        logic [63:0]         pc_branch;
        logic                zero;
    } exmem_t;

    typedef struct packed {
        logic                reg_write;
        logic                mem_to_reg;
        logic [REG_BITS-1:0] rd;
        logic [63:0]         alu;
        logic [63:0]         rdata;
    } memwb_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    exmem_t           exmem_q, exmem_d;
    memwb_t           wb_q, wb_d;
    logic             stall;
    logic             timeout;
    logic             mem_op;
    logic             taken;

    assign mem_op = exmem_q.valid & (exmem_q.mem_read | exmem_q.mem_write);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d         = state_q;
        cnt_d           = cnt_q;
        err_d           = err_q;
        exmem_d         = exmem_q;
        wb_d            = wb_q;
        wb_d.reg_write  = 1'b0;
        wb_d.mem_to_reg = 1'b0;
        stall           = 1'b0;
        timeout         = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (mem_op) begin
                    stall   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (dm_ack) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // Memory never answered: give up, flag it, and let the pipeline move on.
                    timeout = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (!stall) begin
            if (flush_i) begin
                exmem_d = '0;
            end else begin
                exmem_d.valid      = 1'b1;
                exmem_d.reg_write  = RegWrite_E;
                exmem_d.mem_to_reg = MemtoReg_E;
                exmem_d.mem_read   = MemRead_E;
                exmem_d.mem_write  = MemWrite_E;
                exmem_d.branch     = Branch_E;
                exmem_d.rd         = rd_E;
                exmem_d.alu        = aluResult_E;
                exmem_d.wdata      = writeData_E;
                exmem_d.pc_branch  = PCBranch_E;
                exmem_d.zero       = zero_E;
            end

            wb_d.reg_write  = exmem_q.valid & exmem_q.reg_write & ~exmem_q.mem_write & ~timeout;
            wb_d.mem_to_reg = exmem_q.valid & exmem_q.mem_to_reg;
            wb_d.rd         = exmem_q.rd;
            wb_d.alu        = exmem_q.alu;
            if ((state_q == REQ) && dm_ack && exmem_q.mem_read) begin
                wb_d.rdata = dm_rdata;
            end else if (timeout) begin
                wb_d.rdata = '0;
            end
        end
    end

    always_comb begin
        taken = 1'b0;
        case (exmem_q.branch)
            2'b01:   taken = exmem_q.zero;
            2'b10:   taken = 1'b1;
`ifdef CBNZ_EN
            2'b11:   taken = ~exmem_q.zero;
`else
            2'b11:   taken = 1'b0;
`endif
            default: taken = 1'b0;
        endcase
    end

    // Asynchronous reset also abandons an in-flight access: dm_req is decoded from state_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            exmem_q <= '0;
            wb_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            exmem_q <= exmem_d;
            wb_q    <= wb_d;
        end
    end

    assign stall_o     = stall;
    assign PCSrc_M     = exmem_q.valid & taken;
    assign PCBranch_M  = exmem_q.pc_branch;
    assign dm_req      = (state_q == REQ);
    assign dm_we       = (state_q == REQ) & exmem_q.mem_write;
    assign dm_addr     = exmem_q.alu;
    assign dm_wdata    = exmem_q.wdata;
    assign RegWrite_W  = wb_q.reg_write;
    assign MemtoReg_W  = wb_q.mem_to_reg;
    assign rd_W        = wb_q.rd;
    assign aluResult_W = wb_q.alu;
    assign readData_W  = wb_q.rdata;
    assign mem_err_o   = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: transaction-level model with a responding memory and random traffic.
module tb_mem_stage;

    localparam int ACK_TIMEOUT = 16;
    localparam int REG_BITS    = 5;
    localparam int NEVER       = 1000;

    logic                clk = 1'b0;
    logic                reset;
    logic                RegWrite_E, MemtoReg_E, MemRead_E, MemWrite_E;
    logic [1:0]          Branch_E;
    logic [REG_BITS-1:0] rd_E;
    logic [63:0]         aluResult_E, writeData_E, PCBranch_E;
    logic                zero_E, flush_i;
    logic                stall_o, PCSrc_M;
    logic [63:0]         PCBranch_M;
    logic                dm_req, dm_we;
    logic [63:0]         dm_addr, dm_wdata, dm_rdata;
    logic                dm_ack;
    logic                RegWrite_W, MemtoReg_W;
    logic [REG_BITS-1:0] rd_W;
    logic [63:0]         aluResult_W, readData_W;
    logic                mem_err_o;

    mem_stage #(.ACK_TIMEOUT(ACK_TIMEOUT), .REG_BITS(REG_BITS)) dut (
        .clk(clk), .reset(reset),
        .RegWrite_E(RegWrite_E), .MemtoReg_E(MemtoReg_E), .MemRead_E(MemRead_E),
        .MemWrite_E(MemWrite_E), .Branch_E(Branch_E), .rd_E(rd_E),
        .aluResult_E(aluResult_E), .writeData_E(writeData_E), .PCBranch_E(PCBranch_E),
        .zero_E(zero_E), .flush_i(flush_i), .stall_o(stall_o), .PCSrc_M(PCSrc_M),
        .PCBranch_M(PCBranch_M), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .RegWrite_W(RegWrite_W), .MemtoReg_W(MemtoReg_W), .rd_W(rd_W),
        .aluResult_W(aluResult_W), .readData_W(readData_W), .mem_err_o(mem_err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit        flush;
        bit        rw;
        bit        mtr;
        bit        mrd;
        bit        mwr;
        bit [1:0]  br;
        bit [4:0]  rd;
        bit [63:0] alu;
        bit [63:0] wdata;
        bit [63:0] pcb;
        bit        zero;
    } instr_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] mem_model [logic [63:0]];
    logic [63:0] exp_rdata = '0;
    bit          exp_err   = 1'b0;

    function automatic logic [63:0] mem_read(input logic [63:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return 64'hA5A5_0000_0000_0000 ^ a;
    endfunction

    function automatic bit model_taken(input instr_t i);
        if (i.flush) return 1'b0;
        case (i.br)
            2'd1: return i.zero;
            2'd2: return 1'b1;
`ifdef CBNZ_EN
            2'd3: return !i.zero;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        int     kind;
        i       = '0;
        kind    = $urandom_range(0, 9);
        i.rd    = 5'($urandom);
        i.alu   = {$urandom, $urandom};
        i.wdata = {$urandom, $urandom};
        i.pcb   = {$urandom, $urandom};
        i.zero  = 1'($urandom_range(0, 1));
        i.rw    = 1'($urandom_range(0, 1));
        i.mtr   = 1'($urandom_range(0, 1));
        if (kind <= 2) begin
            i.mrd = 1'b1;
            i.alu = 64'(8 * $urandom_range(0, 7));
        end else if (kind <= 4) begin
            i.mwr = 1'b1;
            i.alu = 64'(8 * $urandom_range(0, 7));
        end else if (kind == 8) begin
            i.br = 2'($urandom_range(0, 3));
        end else if (kind == 9) begin
            i.flush = 1'b1;
            i.br    = 2'($urandom_range(0, 3));
            i.mrd   = 1'($urandom_range(0, 1));
        end
        return i;
    endfunction

    task automatic drive_e(input instr_t i);
        flush_i     = i.flush;
        RegWrite_E  = i.rw;
        MemtoReg_E  = i.mtr;
        MemRead_E   = i.mrd;
        MemWrite_E  = i.mwr;
        Branch_E    = i.br;
        rd_E        = i.rd;
        aluResult_E = i.alu;
        writeData_E = i.wdata;
        PCBranch_E  = i.pcb;
        zero_E      = i.zero;
    endtask

    // Entry: just after the edge that loaded ins into the M stage. Exit: just after its retire edge.
    // nxt is presented from execute meanwhile and enters the M stage at that retire edge.
    task automatic process(input instr_t ins, input int lat, input instr_t nxt, output int n_stall);
        bit is_mem, acked, timed_out, exp_rw;
        drive_e(nxt);
        dm_ack   = 1'($urandom_range(0, 1));
        dm_rdata = {$urandom, $urandom};
        #1;
        n_tests++;
        if (PCSrc_M !== model_taken(ins)) begin
            n_fail++; $display("FAIL pcsrc: got %b want %b (br=%0d zero=%b)", PCSrc_M, model_taken(ins), ins.br, ins.zero);
        end
        if (!ins.flush) begin
            n_tests++;
            if (PCBranch_M !== ins.pcb) begin
                n_fail++; $display("FAIL pcbranch: got %h want %h", PCBranch_M, ins.pcb);
            end
        end
        is_mem = !ins.flush && (ins.mrd || ins.mwr);
        n_tests++;
        if (stall_o !== is_mem || dm_req !== 1'b0) begin
            n_fail++; $display("FAIL first_cycle: stall=%b req=%b want stall=%b req=0", stall_o, dm_req, is_mem);
        end
        acked = 1'b0; timed_out = 1'b0;
        n_stall = is_mem ? 1 : 0;
        @(posedge clk); #1;
        if (is_mem) begin
            n_tests++;
            if (RegWrite_W !== 1'b0) begin
                n_fail++; $display("FAIL stall_bubble: RegWrite_W=%b want 0", RegWrite_W);
            end
            for (int k = 0; !(acked || timed_out); k++) begin
                acked     = (k == lat);
                timed_out = !acked && (k == ACK_TIMEOUT - 1);
                dm_ack    = acked;
                dm_rdata  = (acked && ins.mrd) ? mem_read(ins.alu) : {$urandom, $urandom};
                #1;
                n_tests++;
                if (dm_req !== 1'b1 || dm_addr !== ins.alu || dm_we !== ins.mwr ||
                    (ins.mwr && dm_wdata !== ins.wdata)) begin
                    n_fail++; $display("FAIL req_cycle%0d: req=%b we=%b addr=%h wdata=%h want 1 %b %h %h",
                                       k, dm_req, dm_we, dm_addr, dm_wdata, ins.mwr, ins.alu, ins.wdata);
                end
                n_tests++;
                if (stall_o !== !(acked || timed_out)) begin
                    n_fail++; $display("FAIL req_stall%0d: got %b want %b", k, stall_o, !(acked || timed_out));
                end
                @(posedge clk); #1;
                dm_ack = 1'b0;
                if (!(acked || timed_out)) begin
                    n_stall++;
                    n_tests++;
                    if (RegWrite_W !== 1'b0) begin
                        n_fail++; $display("FAIL req_bubble%0d: RegWrite_W=%b want 0", k, RegWrite_W);
                    end
                end
            end
            if (acked && ins.mwr) mem_model[ins.alu] = ins.wdata;
            if (acked && ins.mrd) exp_rdata = mem_read(ins.alu);
            if (timed_out) begin
                exp_rdata = '0;
                exp_err   = 1'b1;
            end
            n_tests++;
            if (n_stall !== (acked ? lat + 1 : ACK_TIMEOUT)) begin
                n_fail++; $display("FAIL stall_count: got %0d want %0d", n_stall, acked ? lat + 1 : ACK_TIMEOUT);
            end
        end else begin
            dm_ack = 1'b0;
        end
        exp_rw = !ins.flush && ins.rw && !(is_mem && ins.mwr) && !timed_out;
        n_tests++;
        if (RegWrite_W !== exp_rw || readData_W !== exp_rdata) begin
            n_fail++; $display("FAIL wb_retire: RegWrite_W=%b readData_W=%h want %b %h", RegWrite_W, readData_W, exp_rw, exp_rdata);
        end
        if (!ins.flush) begin
            n_tests++;
            if (MemtoReg_W !== ins.mtr || rd_W !== ins.rd || aluResult_W !== ins.alu) begin
                n_fail++; $display("FAIL wb_fields: mtr=%b rd=%0d alu=%h want %b %0d %h",
                                   MemtoReg_W, rd_W, aluResult_W, ins.mtr, ins.rd, ins.alu);
            end
        end
        n_tests++;
        if (mem_err_o !== exp_err || dm_req !== 1'b0) begin
            n_fail++; $display("FAIL after_retire: mem_err_o=%b dm_req=%b want %b 0", mem_err_o, dm_req, exp_err);
        end
    endtask

    task automatic run_one(input instr_t ins, input int lat, output int ns);
        drive_e(ins);
        @(posedge clk); #1;
        process(ins, lat, '0, ns);
    endtask

    task automatic run_program(input instr_t prog[$], input int lats[$]);
        instr_t nxt;
        int     ns;
        drive_e(prog[0]);
        @(posedge clk); #1;
        foreach (prog[i]) begin
            nxt = (i + 1 < prog.size()) ? prog[i + 1] : '0;
            process(prog[i], lats[i], nxt, ns);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_e('0);
        dm_ack = 1'b0; dm_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({stall_o, PCSrc_M, dm_req, dm_we, RegWrite_W, MemtoReg_W, mem_err_o} !== 7'b0 ||
            PCBranch_M !== '0 || dm_addr !== '0 || dm_wdata !== '0 || rd_W !== '0 ||
            aluResult_W !== '0 || readData_W !== '0) begin
            n_fail++; $display("FAIL reset_state: some output nonzero (stall=%b req=%b rw=%b err=%b alu=%h rdata=%h)",
                               stall_o, dm_req, RegWrite_W, mem_err_o, aluResult_W, readData_W);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_alu_op();
        instr_t i;
        int     ns;
        i = '0; i.rw = 1'b1; i.rd = 5'd3; i.alu = 64'd14;
        run_one(i, 0, ns);
        n_tests++;
        if (aluResult_W !== 64'd14 || rd_W !== 5'd3 || RegWrite_W !== 1'b1 || ns !== 0) begin
            n_fail++; $display("FAIL alu_op: alu=%0d rd=%0d rw=%b stalls=%0d want 14 3 1 0", aluResult_W, rd_W, RegWrite_W, ns);
        end
    endtask

    task automatic test_branch();
        instr_t i;
        int     ns;
        i = '0; i.br = 2'b01; i.zero = 1'b1; i.pcb = 64'd104;
        drive_e(i);
        @(posedge clk); #1;
        n_tests++;
        if (PCSrc_M !== 1'b1 || PCBranch_M !== 64'd104) begin
            n_fail++; $display("FAIL cbz_taken: pcsrc=%b target=%0d want 1 104", PCSrc_M, PCBranch_M);
        end
        process(i, 0, '0, ns);
        i.zero = 1'b0;
        drive_e(i);
        @(posedge clk); #1;
        n_tests++;
        if (PCSrc_M !== 1'b0) begin
            n_fail++; $display("FAIL cbz_not_taken: pcsrc=%b want 0", PCSrc_M);
        end
        process(i, 0, '0, ns);
        i.br = 2'b11;
        run_one(i, 0, ns);
        i.zero = 1'b1;
        run_one(i, 0, ns);
    endtask

    task automatic test_load();
        instr_t i;
        int     ns;
        mem_model[64'd16] = 64'h0F0F_0F0F_0F0F_0F0F;
        i = '0; i.mrd = 1'b1; i.rw = 1'b1; i.mtr = 1'b1; i.rd = 5'd7; i.alu = 64'd16;
        run_one(i, 3, ns);
        n_tests++;
        if (ns !== 4 || readData_W !== 64'h0F0F_0F0F_0F0F_0F0F || RegWrite_W !== 1'b1) begin
            n_fail++; $display("FAIL load_plan: stalls=%0d rdata=%h rw=%b want 4 0f0f0f0f0f0f0f0f 1", ns, readData_W, RegWrite_W);
        end
    endtask

    task automatic test_store();
        instr_t i;
        int     ns;
        i = '0; i.mwr = 1'b1; i.rw = 1'b1; i.alu = 64'd8; i.wdata = 64'd20;
        run_one(i, 0, ns);
        n_tests++;
        if (ns !== 1 || RegWrite_W !== 1'b0) begin
            n_fail++; $display("FAIL store_plan: stalls=%0d rw=%b want 1 0", ns, RegWrite_W);
        end
        i = '0; i.mrd = 1'b1; i.rw = 1'b1; i.alu = 64'd8;
        run_one(i, 1, ns);
        n_tests++;
        if (readData_W !== 64'd20) begin
            n_fail++; $display("FAIL store_readback: rdata=%0d want 20", readData_W);
        end
    endtask

    task automatic test_flush();
        instr_t i;
        int     ns;
        i = '0; i.flush = 1'b1; i.br = 2'b10; i.rw = 1'b1; i.pcb = 64'h200;
        drive_e(i);
        @(posedge clk); #1;
        n_tests++;
        if (PCSrc_M !== 1'b0) begin
            n_fail++; $display("FAIL flush_branch: pcsrc=%b want 0", PCSrc_M);
        end
        process(i, 0, '0, ns);
        i.flush = 1'b0;
        run_one(i, 0, ns);
    endtask

    task automatic test_back_to_back();
        instr_t prog[$];
        int     lats[$];
        instr_t i;
        i = '0; i.mwr = 1'b1; i.alu = 64'd24; i.wdata = 64'hCAFE;   prog.push_back(i); lats.push_back(0);
        i = '0; i.mrd = 1'b1; i.rw = 1'b1; i.alu = 64'd24; i.rd = 5'd9; prog.push_back(i); lats.push_back(2);
        i = '0; i.mrd = 1'b1; i.rw = 1'b1; i.alu = 64'd16; i.rd = 5'd4; prog.push_back(i); lats.push_back(0);
        i = '0; i.rw = 1'b1; i.rd = 5'd5; i.alu = 64'd77;               prog.push_back(i); lats.push_back(0);
        i = '0; i.br = 2'b10; i.pcb = 64'h40;                           prog.push_back(i); lats.push_back(0);
        i = '0; i.mwr = 1'b1; i.alu = 64'd16; i.wdata = 64'd5;          prog.push_back(i); lats.push_back(4);
        run_program(prog, lats);
    endtask

    task automatic test_timeout();
        instr_t prog[$];
        int     lats[$];
        instr_t i;
        int     ns;
        i = '0; i.mrd = 1'b1; i.rw = 1'b1; i.alu = 64'd16; i.rd = 5'd2;
        run_one(i, NEVER, ns);
        n_tests++;
        if (ns !== ACK_TIMEOUT || mem_err_o !== 1'b1 || RegWrite_W !== 1'b0 || readData_W !== '0 ||
            dm_req !== 1'b0 || stall_o !== 1'b0) begin
            n_fail++; $display("FAIL timeout_plan: stalls=%0d err=%b rw=%b rdata=%h req=%b stall=%b",
                               ns, mem_err_o, RegWrite_W, readData_W, dm_req, stall_o);
        end
        for (int n = 0; n < 4; n++) begin
            prog.push_back(rand_instr());
            lats.push_back($urandom_range(0, 3));
        end
        run_program(prog, lats);
    endtask

    task automatic test_reset_mid_access();
        instr_t i;
        i = '0; i.mwr = 1'b1; i.alu = 64'd48; i.wdata = 64'h1234;
        drive_e(i);
        @(posedge clk); #1;
        drive_e('0);
        dm_ack = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (dm_req !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset_setup: dm_req=%b want 1", dm_req);
        end
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if ({stall_o, PCSrc_M, dm_req, dm_we, RegWrite_W, MemtoReg_W, mem_err_o} !== 7'b0 ||
            dm_addr !== '0 || dm_wdata !== '0 || aluResult_W !== '0 || readData_W !== '0 || rd_W !== '0) begin
            n_fail++; $display("FAIL mid_reset: req=%b stall=%b err=%b addr=%h rdata=%h want all 0",
                               dm_req, stall_o, mem_err_o, dm_addr, readData_W);
        end
        exp_err   = 1'b0;
        exp_rdata = '0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        instr_t prog[$];
        int     lats[$];
        for (int n = 0; n < 150; n++) begin
            prog.push_back(rand_instr());
            lats.push_back(($urandom_range(0, 39) == 0) ? NEVER : $urandom_range(0, 5));
        end
        run_program(prog, lats);
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_branch();
        test_load();
        test_store();
        test_flush();
        test_back_to_back();
        test_random();
        test_timeout();
        test_reset_mid_access();
        test_alu_op();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 64-bit LEGv8 pipeline, directly downstream of the execute stage.
- Holds the EX/MEM pipeline register and resolves CBZ/B branches from the registered zero flag and branch target.
- Drives a variable-latency data memory over a req/ack handshake and stalls upstream stages while an access is outstanding.
- Produces the MEM/WB register contents consumed by writeback.

Parameters:
ACK_TIMEOUT, 16, cycles in REQ without dm_ack before the access is aborted (min 2).
REG_BITS, 5, destination register index width.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-high reset.
RegWrite_E  in  1  register write enable from execute.
MemtoReg_E  in  1  writeback source select.
MemRead_E  in  1  load.
MemWrite_E  in  1  store.
Branch_E  in  2  00 none, 01 CBZ, 10 unconditional B, 11 CBNZ (see Optional Feature).
rd_E  in  REG_BITS  destination register.
aluResult_E  in  64  ALU result, used as memory address.
writeData_E  in  64  store data.
PCBranch_E  in  64  branch target.
zero_E  in  1  ALU zero flag.
flush_i  in  1  replace the incoming instruction with a bubble.
stall_o  out  1  upstream must hold PC, IF/ID and ID/EX.
PCSrc_M  out  1  branch taken.
PCBranch_M  out  64  registered branch target.
dm_req  out  1  memory request.
dm_we  out  1  1 = write.
dm_addr  out  64  memory address.
dm_wdata  out  64  store data.
dm_rdata  in  64  load data, valid while dm_ack=1.
dm_ack  in  1  access complete.
RegWrite_W  out  1  writeback enable.
MemtoReg_W  out  1  writeback source select.
rd_W  out  REG_BITS  writeback register.
aluResult_W  out  64  registered ALU result.
readData_W  out  64  registered load data.
mem_err_o  out  1  sticky timeout error.

Behaviour:
- Reset: all outputs and registers are 0, EX/MEM valid=0, FSM in IDLE, timeout counter 0, mem_err_o=0.
- EX/MEM register:
  - Loads all *_E inputs at a rising edge when stall_o=0.
  - If flush_i=1 at that edge, loads a bubble instead: valid=0, all enables 0.
  - flush_i is sampled only when stall_o=0; the hazard unit holds it until it is accepted.
- Branch resolution (combinational from the EX/MEM register):
  - PCSrc_M = valid & (Branch==10 | (Branch==01 & zero)).
  - PCBranch_M is the registered target.
- FSM states:
  - IDLE: if valid & (MemRead|MemWrite), stall_o=1 and next state is REQ. Otherwise stall_o=0 and the instruction retires in one cycle.
  - REQ: dm_req=1 and dm_we=MemWrite; dm_addr and dm_wdata come from the register; stall_o = !dm_ack.
    - On dm_ack: capture dm_rdata into readData_W and return to IDLE. Because stall_o=0 in that cycle, the same edge loads the next instruction from execute.
- Memory op latency: minimum 2 cycles in the M stage (ack in the first REQ cycle). Non-memory ops take 1 cycle.
- MEM/WB register:
  - Updates every edge.
  - While stall_o=1 it loads a bubble (RegWrite_W=0).
  - For a retiring store, RegWrite_W=0 regardless of RegWrite_E.
  - readData_W holds its previous value for non-load instructions.
- Timeout:
  - The counter increments each REQ cycle without ack.
  - When the count reaches ACK_TIMEOUT-1 with no ack: drop dm_req, set mem_err_o (cleared only by reset), and retire the instruction with RegWrite_W=0 and readData_W=0. Return to IDLE; stall_o=0 that cycle.
- Ack outside REQ is ignored.
- Reset mid-access: dm_req drops immediately (asynchronous) and the access is abandoned.

Optional Feature:
- Macro: CBNZ_EN.
- Defined: Branch==11 is taken when valid & !zero.
- Undefined: Branch==11 is treated as 00 (never taken).

Test Plan:
- Non-memory op: aluResult_E=14, RegWrite_E=1, rd_E=3, Branch_E=00 → after 1 edge PCSrc_M=0; next edge aluResult_W=14, rd_W=3, RegWrite_W=1; stall_o never asserted.
- CBZ: Branch_E=01, zero_E=1, PCBranch_E=104 → after 1 edge PCSrc_M=1, PCBranch_M=104. Repeat with zero_E=0 → PCSrc_M=0.
- Load, ack 3 cycles after request: MemRead_E=1, aluResult_E=16, dm_rdata=0x0F0F0F0F0F0F0F0F → dm_addr=16, dm_we=0, stall_o=1 for 4 cycles. Then readData_W=0x0F0F0F0F0F0F0F0F, RegWrite_W=1, and RegWrite_W=0 on each stall cycle.
- Store: MemWrite_E=1, aluResult_E=8, writeData_E=20, immediate ack → dm_we=1, dm_wdata=20, 2-cycle stage occupancy, RegWrite_W=0.
- Timeout: load with dm_ack held 0 → after ACK_TIMEOUT (16) REQ cycles dm_req=0, mem_err_o=1, RegWrite_W=0, stall_o=0. mem_err_o stays 1 until reset.
- Flush and reset: flush_i=1 with Branch_E=10 → PCSrc_M=0 next cycle. Assert reset during REQ → dm_req=0 and all outputs 0 immediately.
